// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, datapath width and FSM states.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_illegal(input logic [2:0] fun);
    return (fun == 3'd0) || (fun == 3'd7);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; every op is evaluated 33 bits wide so bit 32 is the carry.
module alu
  import alu_pkg::*;
(
  input  logic [2:0]        i_fun,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero,
  output logic              o_negative
);

  logic [DATA_W:0] w_wide;

  always_comb begin
    w_wide = '0;
    case (i_fun)
      OP_ADD:  w_wide = {1'b0, i_b} + {1'b0, i_a};
      OP_SUB:  w_wide = {1'b0, i_b} - {1'b0, i_a};
      OP_NOT:  w_wide = ~{1'b0, i_b};
      OP_AND:  w_wide = {1'b0, i_b & i_a};
      OP_OR:   w_wide = {1'b0, i_b | i_a};
      OP_XOR:  w_wide = {1'b0, i_b ^ i_a};
      default: w_wide = '0;
    endcase
  end

  // zero looks at all 33 bits, so an add that wraps to 0 still reports zero=0
  assign o_result   = w_wide[DATA_W-1:0];
  assign o_carry    = w_wide[DATA_W];
  assign o_zero     = (w_wide == '0);
  assign o_negative = (i_fun == OP_SUB) && (i_b < i_a);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one op in flight,
// result held in a response register until the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_fun,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_fun,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              rsp_negative,
  output logic              rsp_illegal,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
  // high; a requester holds valid and its fields stable until it sees ready.

  state_t            r_state, w_next_state;
  logic              r_rr_ptr;
  logic [2:0]        r_fun;
  logic [DATA_W-1:0] r_a, r_b;
  logic              r_id;
  logic              r_rsp_valid, r_rsp_id, r_rsp_carry, r_rsp_zero, r_rsp_negative, r_rsp_illegal;
  logic [DATA_W-1:0] r_rsp_result;

  logic              w_grant0, w_grant1, w_accept;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry, w_alu_zero, w_alu_negative;

  // A lone requester always wins; on a tie the pointer decides.
  assign w_grant0 = req0_valid & (~req1_valid | ~r_rr_ptr);
  assign w_grant1 = req1_valid & (~req0_valid |  r_rr_ptr);
  assign w_accept = req0_ready | req1_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (r_state == IDLE) & ~reset & w_grant0;
    req1_ready = (r_state == IDLE) & ~reset & w_grant1;
    busy       = (r_state != IDLE);
    dbg_state  = r_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr       <= RR_INIT;
      r_fun          <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_id           <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_carry    <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_negative <= 1'b0;
      r_rsp_illegal  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fun    <= req1_ready ? req1_fun : req0_fun;
        r_a      <= req1_ready ? req1_a   : req0_a;
        r_b      <= req1_ready ? req1_b   : req0_b;
        r_id     <= req1_ready;
        r_rr_ptr <= ~req1_ready;
      end
      if (r_state == EXEC) begin
        r_rsp_valid    <= 1'b1;
        r_rsp_id       <= r_id;
        r_rsp_result   <= w_alu_result;
        r_rsp_carry    <= w_alu_carry;
        r_rsp_zero     <= w_alu_zero;
        r_rsp_negative <= w_alu_negative;
        r_rsp_illegal  <= is_illegal(r_fun);
      end else if ((r_state == RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  alu u_alu (
    .i_fun      (r_fun),
    .i_a        (r_a),
    .i_b        (r_b),
    .o_result   (w_alu_result),
    .o_carry    (w_alu_carry),
    .o_zero     (w_alu_zero),
    .o_negative (w_alu_negative)
  );

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_result   = r_rsp_result;
  assign rsp_carry    = r_rsp_carry;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_negative = r_rsp_negative;
  assign rsp_illegal  = r_rsp_illegal;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit `alu` datapath between two requesters, e.g. the instruction sequencer (port 0) and the address/loop unit (port 1).
- Arbitration is round-robin. Operands and op code are captured on a valid/ready handshake.
- The op runs through the combinational ALU from registered operands. Result and flags are held in a response register until consumed.
- One op in flight at a time; no pipelining.

Parameters:
- DATA_W, 32, operand/result width. Only 32 is supported because the ALU width is fixed.
- RR_INIT, 0, requester that has priority after reset (0 or 1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an op pending
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_fun  in  3  ALU op code for requester 0
- req0_a  in  32  operand A (operA) for requester 0
- req0_b  in  32  operand B (operB) for requester 0
- req1_valid, req1_ready, req1_fun, req1_a, req1_b: same as requester 0, for requester 1
- rsp_valid  out  1  response register holds a completed op
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester that issued the op
- rsp_result  out  32  ALU result
- rsp_carry  out  1  ALU carry flag
- rsp_zero  out  1  ALU zero flag
- rsp_negative  out  1  ALU negative flag
- rsp_illegal  out  1  op code was not in 1..6
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, rr_ptr=RR_INIT.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry/zero/negative/illegal=0.
  - busy=0, both readies=0.
  - Reset asserted mid-operation drops the op silently; no response is produced.
- FSM IDLE:
  - readyX = stateIDLE & validX & granted(X), combinational. At most one ready is high.
  - Grant rule: only one valid → that requester. Both valid → rr_ptr requester.
  - On handshake: latch fun/a/b/id, rr_ptr ← ~id, go to EXEC.
- FSM EXEC (1 cycle):
  - Latched operands drive `alu`.
  - rsp_* ← ALU outputs; rsp_illegal ← (fun==0 | fun==7).
  - rsp_valid ← 1, go to RESP.
- FSM RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready: rsp_valid ← 0, go to IDLE. A new grant can happen the next cycle.
- Latency and throughput:
  - Latency from handshake to rsp_valid is 2 clk.
  - Minimum spacing between accepts is 3 clk when rsp_ready is tied high.
- Round robin: after a grant, the other requester wins the next tie. A non-requesting port does not hold priority hostage.
- ALU semantics (existing datapath, fixed codes; forwarded unmodified):
  - Op codes: 1 add B+A, 2 sub B−A, 3 not ~B, 4 and, 5 or, 6 xor, other → result 0.
  - Operations are evaluated 33 bits wide. carry = bit 32. zero = all 33 bits are 0.
  - negative = (sub and B<A, unsigned).
  - Consequences: add overflow gives carry=1, zero=0 even when the 32-bit result is 0. Sub with B<A gives carry=1 and negative=1. not always gives carry=1, zero=0. Illegal codes give result 0, zero=1, carry=0.
- Requests arriving while busy: they wait; validX must stay high and its fields stable until readyX.
- Back-to-back from the same port: if the other port is idle, the same port is granted again.

Decomposition:
- Shared package `alu_pkg`: op code constants OP_ADD=1, OP_SUB=2, OP_NOT=3, OP_AND=4, OP_OR=5, OP_XOR=6; DATA_W; FSM state encoding IDLE/EXEC/RESP.
- Sub-module: one instance of the existing `alu`, fed from the latched operand registers. Arbitration and the FSM stay inline.

Test Plan:
- Reset → all rsp_* = 0, busy=0, readies 0. Then req0 add a=5, b=7 → req0_ready same cycle, rsp_valid 2 clk later, result=12, carry=0, zero=0, rsp_id=0.
- Both valid every cycle, RR_INIT=0, rsp_ready=1 → grant order 0,1,0,1; accepts every 3 clk.
- req1 sub a=9, b=4 → result 0xFFFFFFFB, carry=1, negative=1, zero=0. Then add a=1, b=0xFFFFFFFF → result 0, carry=1, zero=0.
- not b=0xFFFFFFFF → result 0, carry=1, zero=0. fun=7 → result 0, zero=1, illegal=1.
- rsp_ready=0 for 5 clk → rsp_* stable, busy=1, req readies 0. rsp_ready=1 → rsp_valid drops next clk.
- reset pulse while in EXEC → rsp_valid stays 0 and the dropped op never appears. rr_ptr=RR_INIT, so the next tie goes to RR_INIT.
